// File: rtl/led_matrix_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_matrix_scanner: row-scanning bi-colour LED matrix driver with a        |
// | double-buffered frame store, per-row blanking and global PWM brightness.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module led_matrix_scanner #(
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int DWELL_DIV = 10,
  parameter int BLANK_CYC = 4,
  parameter int PWM_BITS  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           EnableCount,
  input  logic [ROWS-1:0][COLS-1:0]      RedPixels,
  input  logic [ROWS-1:0][COLS-1:0]      GrnPixels,
  input  logic                           frame_valid,
  output logic                           frame_ack,
  output logic                           frame_tick,
  input  logic [PWM_BITS-1:0]            brightness,
  output logic [$clog2(ROWS)-1:0]        row_sel,
  output logic [COLS-1:0]                red_cols,
  output logic [COLS-1:0]                grn_cols
);

  localparam int ROW_W = $clog2(ROWS);

  localparam logic [DWELL_DIV-1:0] c_DWELL_MAX = '1;
  localparam logic [DWELL_DIV-1:0] c_BLANK     = DWELL_DIV'(BLANK_CYC);
  localparam logic [ROW_W-1:0]     c_LAST_ROW  = ROW_W'(ROWS - 1);

  logic [ROW_W-1:0]            r_row;
  logic [DWELL_DIV-1:0]        r_dwell;
  logic [PWM_BITS-1:0]         r_pwm;
  logic [ROWS-1:0][COLS-1:0]   r_shadow_red;
  logic [ROWS-1:0][COLS-1:0]   r_shadow_grn;

  logic                        w_dwell_wrap;
  logic                        w_frame_end;
  logic                        w_show;
  logic                        w_first_show;
  logic [PWM_BITS-1:0]         w_pwm;
  logic                        w_en;
  logic [COLS-1:0]             w_red_row;
  logic [COLS-1:0]             w_grn_row;
  logic [COLS-1:0]             w_red_next;
  logic [COLS-1:0]             w_grn_next;

  assign w_dwell_wrap = (r_dwell == c_DWELL_MAX);
  assign w_frame_end  = w_dwell_wrap && (r_row == c_LAST_ROW);
  assign w_show       = (r_dwell >= c_BLANK);
  assign w_first_show = (r_dwell == c_BLANK);
  // The PWM phase restarts at the first SHOW cycle so every row sees the same duty.
  assign w_pwm        = w_first_show ? '0 : r_pwm;
  assign w_en         = w_show && (w_pwm < brightness);
  assign w_red_row    = r_shadow_red[r_row];
  assign w_grn_row    = r_shadow_grn[r_row];

  // Pixel column c drives header bit COLS-1-c.
  always_comb begin
    w_red_next = '0;
    w_grn_next = '0;
    for (int c = 0; c < COLS; c++) begin
      w_red_next[COLS-1-c] = w_red_row[c] & w_en;
      w_grn_next[COLS-1-c] = w_grn_row[c] & w_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row        <= '0;
      r_dwell      <= '0;
      r_pwm        <= '0;
      r_shadow_red <= '0;
      r_shadow_grn <= '0;
      frame_ack    <= 1'b0;
      frame_tick   <= 1'b0;
      row_sel      <= '0;
      red_cols     <= '0;
      grn_cols     <= '0;
    end else if (EnableCount) begin
      r_dwell <= r_dwell + DWELL_DIV'(1);
      if (w_dwell_wrap) begin
        r_row <= (r_row == c_LAST_ROW) ? '0 : r_row + ROW_W'(1);
      end
      if (w_show) begin
        r_pwm <= w_pwm + PWM_BITS'(1);
      end
      if (w_frame_end && frame_valid) begin
        r_shadow_red <= RedPixels;
        r_shadow_grn <= GrnPixels;
      end
      frame_tick <= w_frame_end;
      frame_ack  <= w_frame_end && frame_valid;
      row_sel    <= r_row;
      red_cols   <= w_red_next;
      grn_cols   <= w_grn_next;
    end else begin
      frame_tick <= 1'b0;
      frame_ack  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_led_matrix_scanner: directed self-checking bench for led_matrix_scanner |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_led_matrix_scanner;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  EnableCount;
  logic [3:0][3:0]       RedPixels;
  logic [3:0][3:0]       GrnPixels;
  logic                  frame_valid;
  logic                  frame_ack;
  logic                  frame_tick;
  logic [1:0]            brightness;
  logic [1:0]            row_sel;
  logic [3:0]            red_cols;
  logic [3:0]            grn_cols;

  int n_checks = 0;
  int n_errors = 0;

  // Column pattern over dwell 0..7 for an all-ones row at brightness 3.
  logic [3:0] tbl3 [8] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF};
  // grn_cols while row 1 is shown with only GrnPixels[1][0] set, brightness 3.
  logic [3:0] g1   [8] = '{4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h8, 4'h8};
  logic [1:0] bri  [4] = '{2'd2, 2'd0, 2'd1, 2'd3};
  int         lit  [4] = '{4, 0, 2, 5};

  always #5 clk = ~clk;

  led_matrix_scanner #(
    .ROWS(4), .COLS(4), .DWELL_DIV(3), .BLANK_CYC(2), .PWM_BITS(2)
  ) dut (
    .clk(clk), .reset(reset), .EnableCount(EnableCount),
    .RedPixels(RedPixels), .GrnPixels(GrnPixels),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .frame_tick(frame_tick),
    .brightness(brightness), .row_sel(row_sel),
    .red_cols(red_cols), .grn_cols(grn_cols)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    // 1. Reset and free-running scan with an empty shadow
    reset = 1'b1; EnableCount = 1'b1; frame_valid = 1'b0;
    RedPixels = '0; GrnPixels = '0; brightness = 2'd3;
    repeat (2) begin
      tick();
      chk("rst_row", row_sel, 0);
      chk("rst_red", red_cols, 0);
      chk("rst_grn", grn_cols, 0);
      chk("rst_ack", frame_ack, 0);
      chk("rst_tick", frame_tick, 0);
    end
    reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("scan_row", row_sel, ((k - 1) / 8) % 4);
      chk("scan_tick", frame_tick, (k == 32));
      chk("scan_ack", frame_ack, 0);
      chk("scan_red", red_cols, 0);
    end

    // 2. Load handshake
    frame_valid = 1'b1; GrnPixels[1][0] = 1'b1; brightness = 2'd3;
    for (int k = 33; k <= 64; k++) begin
      tick();
      chk("load_ack", frame_ack, (k == 64));
      chk("load_tick", frame_tick, (k == 64));
    end
    frame_valid = 1'b0;
    for (int k = 65; k <= 96; k++) begin
      tick();
      chk("hs_row", row_sel, (k - 65) / 8);
      chk("hs_grn", grn_cols, ((k - 65) / 8 == 1) ? g1[(k - 65) % 8] : 4'h0);
      chk("hs_red", red_cols, 0);
      chk("hs_ack", frame_ack, 0);
    end

    // 3. Brightness with an all-ones frame
    RedPixels = '1; GrnPixels = '1; frame_valid = 1'b1;
    for (int k = 97; k <= 128; k++) begin
      tick();
      if (k == 128) chk("bri_ack", frame_ack, 1);
    end
    frame_valid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      brightness = bri[r];
      cnt = 0;
      for (int d = 0; d < 8; d++) begin
        tick();
        chk("bri_row", row_sel, r);
        chk("bri_grn_eq", grn_cols, red_cols);
        if (red_cols == 4'hF) cnt++;
      end
      chk("bri_lit", cnt, lit[r]);
    end

    // 4. Freeze mid-row
    brightness = 2'd3;
    repeat (3) tick();
    chk("frz_pre_red", red_cols, 4'hF);
    chk("frz_pre_row", row_sel, 0);
    EnableCount = 1'b0;
    repeat (20) begin
      tick();
      chk("frz_row", row_sel, 0);
      chk("frz_red", red_cols, 4'hF);
      chk("frz_tick", frame_tick, 0);
      chk("frz_ack", frame_ack, 0);
    end
    EnableCount = 1'b1;
    for (int k = 164; k <= 169; k++) begin
      tick();
      chk("frz_resume_red", red_cols, tbl3[(k - 1) % 8]);
      chk("frz_resume_row", row_sel, ((k - 1) / 8) % 4);
    end

    // 5. New input data without frame_valid is ignored
    RedPixels = '0; GrnPixels = '0;
    for (int k = 170; k <= 224; k++) begin
      tick();
      chk("nv_ack", frame_ack, 0);
      chk("nv_tick", frame_tick, (k % 32 == 0));
      chk("nv_red", red_cols, tbl3[(k - 1) % 8]);
      chk("nv_row", row_sel, ((k - 1) / 8) % 4);
    end

    // 6. Reset while row 2 is displayed
    repeat (19) tick();
    chk("mr_pre_row", row_sel, 2);
    chk("mr_pre_red", red_cols, 4'hF);
    reset = 1'b1;
    tick();
    chk("mr_row", row_sel, 0);
    chk("mr_red", red_cols, 0);
    chk("mr_grn", grn_cols, 0);
    chk("mr_ack", frame_ack, 0);
    chk("mr_tick", frame_tick, 0);
    reset = 1'b0; RedPixels = '1; frame_valid = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("mr_dark_red", red_cols, 0);
      chk("mr_dark_row", row_sel, ((k - 1) / 8) % 4);
      chk("mr_reload_ack", frame_ack, (k == 32));
    end
    frame_valid = 1'b0;
    tick();
    chk("mr_new_blank", red_cols, 0);
    tick();
    tick();
    chk("mr_new_show", red_cols, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
